// File: rtl/hline_mem_arb.sv
// Two-requester arbiter/sequencer for the single AXI master port of the hline z-buffer pipeline.
// Round-robin between the read and write engines, with an urgent-write override bounded by a starvation guard.
module hline_mem_arb #(
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 8,
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [LEN_W-1:0]  rd_len,
    output logic              rd_gnt,
    output logic              rd_done,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [LEN_W-1:0]  wr_len,
    input  logic              wr_urgent,
    output logic              wr_gnt,
    output logic              wr_done,
    output logic              m_req,
    output logic              m_rnw,
    output logic [ADDR_W-1:0] m_addr,
    output logic [LEN_W-1:0]  m_len,
    input  logic              m_ack,
    input  logic              m_done,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;      // 1: the write engine won last
    logic [SW-1:0]     starve_q, starve_d;
    logic              urg_q, urg_d;        // current write won via urgency while a read waited
    logic              rd_gnt_q, rd_gnt_d;
    logic              wr_gnt_q, wr_gnt_d;
    logic              rd_done_q, rd_done_d;
    logic              wr_done_q, wr_done_d;
    logic              m_req_q, m_req_d;
    logic              m_rnw_q, m_rnw_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [LEN_W-1:0]  m_len_q, m_len_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic              pick_wr;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        starve_d  = starve_q;
        urg_d     = urg_q;
        rd_gnt_d  = rd_gnt_q;
        wr_gnt_d  = wr_gnt_q;
        rd_done_d = 1'b0;
        wr_done_d = 1'b0;
        m_req_d   = m_req_q;
        m_rnw_d   = m_rnw_q;
        m_addr_d  = m_addr_q;
        m_len_d   = m_len_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        pick_wr   = 1'b0;

        case (state_q)
            IDLE: begin
                if (rd_req || wr_req) begin
                    if (wr_req && wr_urgent && (starve_q < STARVE_LIM)) begin
                        pick_wr = 1'b1;
                        urg_d   = rd_req;
                    end else begin
                        pick_wr = (rd_req && wr_req) ? !last_q : wr_req;
                        urg_d   = 1'b0;
                    end
                    rd_gnt_d = !pick_wr;
                    wr_gnt_d = pick_wr;
                    m_req_d  = 1'b1;
                    m_rnw_d  = !pick_wr;
                    m_addr_d = pick_wr ? wr_addr : rd_addr;
                    m_len_d  = pick_wr ? wr_len : rd_len;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (m_ack) begin
                    m_req_d = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (m_done) begin
                    rd_gnt_d = 1'b0;
                    wr_gnt_d = 1'b0;
                    last_d   = wr_gnt_q;
                    if (wr_gnt_q) begin
                        wr_done_d = 1'b1;
                        if (!(&wr_cnt_q)) wr_cnt_d = wr_cnt_q + CNT_W'(1);
                        if (urg_q && (starve_q < STARVE_LIM)) starve_d = starve_q + SW'(1);
                    end else begin
                        rd_done_d = 1'b1;
                        if (!(&rd_cnt_q)) rd_cnt_d = rd_cnt_q + CNT_W'(1);
                        starve_d = '0;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset abandons any burst in flight without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            starve_q  <= '0;
            urg_q     <= 1'b0;
            rd_gnt_q  <= 1'b0;
            wr_gnt_q  <= 1'b0;
            rd_done_q <= 1'b0;
            wr_done_q <= 1'b0;
            m_req_q   <= 1'b0;
            m_rnw_q   <= 1'b0;
            m_addr_q  <= '0;
            m_len_q   <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            starve_q  <= starve_d;
            urg_q     <= urg_d;
            rd_gnt_q  <= rd_gnt_d;
            wr_gnt_q  <= wr_gnt_d;
            rd_done_q <= rd_done_d;
            wr_done_q <= wr_done_d;
            m_req_q   <= m_req_d;
            m_rnw_q   <= m_rnw_d;
            m_addr_q  <= m_addr_d;
            m_len_q   <= m_len_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    assign rd_gnt  = rd_gnt_q;
    assign wr_gnt  = wr_gnt_q;
    assign rd_done = rd_done_q;
    assign wr_done = wr_done_q;
    assign m_req   = m_req_q;
    assign m_rnw   = m_rnw_q;
    assign m_addr  = m_addr_q;
    assign m_len   = m_len_q;
    assign rd_cnt  = rd_cnt_q;
    assign wr_cnt  = wr_cnt_q;

endmodule
